// File: rtl/arbiter_pkg.sv
// Shared definitions for the weighted round-robin arbiter family:
// grant-hold mode encodings and the grant-index width helper.
package arbiter_pkg;

  localparam int HOLD_NONE = 0;
  localparam int HOLD_REQ  = 1;
  localparam int HOLD_ACK  = 2;

  // Index width for an N-way selector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the winning bit (lowest or highest index, per LSB_HIGH).
module priority_encoder
  import arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LSB_HIGH = 1
) (
  input  logic [WIDTH-1:0]            req,
  output logic                        valid,
  output logic [idx_width(WIDTH)-1:0] index
);

  localparam int IDX_W = idx_width(WIDTH);

  assign valid = |req;

  // Later assignments win, so scan from the lowest-priority end.
  always_comb begin
    index = '0;
    if (LSB_HIGH != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) index = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i]) index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with per-port credit counters, selectable
// grant-hold behaviour and a watchdog that revokes an unacknowledged grant.
module arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int PORTS                 = 4,
  parameter int WEIGHT_W              = 4,
  parameter int ARB_LSB_HIGH_PRIORITY = 0,
  parameter int HOLD_MODE             = 2,
  parameter int TIMEOUT               = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_W-1:0]     weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [idx_width(PORTS)-1:0]   grant_encoded,
  output logic                          timeout_evt
);

  localparam int IDX_W   = idx_width(PORTS);
  localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [PORTS-1:0] ALL_ONES = '1;

  logic [PORTS-1:0] grant_reg, grant_next;
  logic             grant_valid_reg, grant_valid_next;
  logic [IDX_W-1:0] grant_enc_reg, grant_enc_next;
  logic             timeout_evt_reg, timeout_evt_next;
  logic [PORTS-1:0] mask_reg, mask_next;
  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;

  logic [PORTS-1:0] cred_nz, eligible, arb_set, arb_masked;
  logic             ack_hit, reload, hold, keep, wd_fire;
  logic             any_all, any_mask;
  logic [IDX_W-1:0] idx_all, idx_mask;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;

  assign ack_hit = grant_valid_reg && acknowledge[grant_enc_reg];
  assign wd_fire = (TIMEOUT > 0) && grant_valid_reg && !ack_hit
                   && (wd_cnt_reg == CNT_W'(WD_LAST));

  // Per-port credit counter; cred_nz reflects the credit after this cycle's ack.
  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      logic [WEIGHT_W-1:0] credit_reg, credit_next, credit_dec, wt;
      logic                is_grantee;

      assign wt         = weight[gi*WEIGHT_W +: WEIGHT_W];
      assign is_grantee = (grant_enc_reg == IDX_W'(gi));
      assign credit_dec = (ack_hit && is_grantee && credit_reg != '0)
                          ? credit_reg - 1'b1 : credit_reg;
      assign cred_nz[gi] = (credit_dec != '0);

      always_comb begin
        credit_next = credit_dec;
        if (wd_fire && is_grantee)
          credit_next = '0;
        else if (reload)
          credit_next = (wt == '0) ? WEIGHT_W'(1) : wt;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) credit_reg <= '0;
        else        credit_reg <= credit_next;
      end
    end
  endgenerate

  assign eligible   = request & cred_nz;
  assign reload     = (|request) && (eligible == '0) && !wd_fire;
  assign arb_set    = reload ? request : eligible;
  assign arb_masked = arb_set & mask_reg;

  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH(ARB_LSB_HIGH_PRIORITY)) u_pe_all (
    .req   (arb_set),
    .valid (any_all),
    .index (idx_all)
  );

  priority_encoder #(.WIDTH(PORTS), .LSB_HIGH(ARB_LSB_HIGH_PRIORITY)) u_pe_mask (
    .req   (arb_masked),
    .valid (any_mask),
    .index (idx_mask)
  );

  // Ports strictly after k in scan direction.
  function automatic logic [PORTS-1:0] rr_mask(input logic [IDX_W-1:0] k);
    if (ARB_LSB_HIGH_PRIORITY != 0) rr_mask = ALL_ONES << (int'(k) + 1);
    else                            rr_mask = ALL_ONES >> (PORTS - int'(k));
  endfunction

  always_comb begin
    case (HOLD_MODE)
      HOLD_NONE: hold = 1'b0;
      HOLD_REQ:  hold = grant_valid_reg && request[grant_enc_reg];
      HOLD_ACK:  hold = grant_valid_reg && !ack_hit;
      default:   hold = 1'b0;
    endcase
  end

  assign keep = grant_valid_reg && request[grant_enc_reg] && cred_nz[grant_enc_reg];

  always_comb begin
    grant_valid_next = grant_valid_reg;
    grant_enc_next   = grant_enc_reg;
    mask_next        = mask_reg;
    timeout_evt_next = 1'b0;
    sel_valid        = 1'b0;
    sel_idx          = '0;

    if (wd_fire) begin
      grant_valid_next = 1'b0;
      grant_enc_next   = '0;
      timeout_evt_next = 1'b1;
    end else if (!hold) begin
      if (keep) begin
        sel_valid = 1'b1;
        sel_idx   = grant_enc_reg;
      end else if (any_mask) begin
        sel_valid = 1'b1;
        sel_idx   = idx_mask;
      end else if (any_all) begin
        sel_valid = 1'b1;
        sel_idx   = idx_all;
      end
      grant_valid_next = sel_valid;
      grant_enc_next   = sel_idx;
      if (sel_valid) mask_next = rr_mask(sel_idx);
    end

    grant_next = grant_valid_next ? (PORTS'(1) << grant_enc_next) : '0;

    // Count unacknowledged cycles of one uninterrupted grant.
    wd_cnt_next = '0;
    if ((TIMEOUT > 0) && !wd_fire && grant_valid_reg && !ack_hit
        && grant_valid_next && (grant_enc_next == grant_enc_reg))
      wd_cnt_next = wd_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      grant_enc_reg   <= '0;
      timeout_evt_reg <= 1'b0;
      mask_reg        <= '0;
      wd_cnt_reg      <= '0;
    end else begin
      grant_reg       <= grant_next;
      grant_valid_reg <= grant_valid_next;
      grant_enc_reg   <= grant_enc_next;
      timeout_evt_reg <= timeout_evt_next;
      mask_reg        <= mask_next;
      wd_cnt_reg      <= wd_cnt_next;
    end
  end

  assign grant         = grant_reg;
  assign grant_valid   = grant_valid_reg;
  assign grant_encoded = grant_enc_reg;
  assign timeout_evt   = timeout_evt_reg;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr: dut_a = LSB priority, hold-until-ack, watchdog 8;
// dut_b = MSB priority, hold-while-request, no watchdog.
module tb_arbiter_wrr;

  localparam int P  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [P-1:0]  req_a, ack_a, req_b, ack_b;
  logic [P*WW-1:0] weight;
  logic [P-1:0]  grant_a, grant_b;
  logic          valid_a, valid_b, to_a, to_b;
  logic [1:0]    enc_a, enc_b;

  always #5 clk = ~clk;

  arbiter_wrr #(.PORTS(P), .WEIGHT_W(WW), .ARB_LSB_HIGH_PRIORITY(1),
                .HOLD_MODE(2), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .request(req_a), .acknowledge(ack_a),
    .weight(weight), .grant(grant_a), .grant_valid(valid_a),
    .grant_encoded(enc_a), .timeout_evt(to_a)
  );

  arbiter_wrr #(.PORTS(P), .WEIGHT_W(WW), .ARB_LSB_HIGH_PRIORITY(0),
                .HOLD_MODE(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .request(req_b), .acknowledge(ack_b),
    .weight(weight), .grant(grant_b), .grant_valid(valid_b),
    .grant_encoded(enc_b), .timeout_evt(to_b)
  );

  typedef struct {
    bit         sel;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] exp_grant;
    logic       exp_valid;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic void add(bit sel, logic [3:0] r, logic [3:0] a,
                              logic [3:0] eg, logic ev, logic eto);
    vec_t v;
    v.sel = sel; v.req = r; v.ack = a; v.exp_grant = eg; v.exp_valid = ev; v.exp_to = eto;
    vecs.push_back(v);
  endfunction

  function automatic logic [1:0] onehot_idx(logic [3:0] g);
    onehot_idx = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) onehot_idx = 2'(i);
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_dut(bit sel, logic [3:0] eg, logic ev, logic eto, string tag);
    logic [3:0] g;
    logic       v, t;
    logic [1:0] e;
    g = sel ? grant_b : grant_a;
    v = sel ? valid_b : valid_a;
    t = sel ? to_b    : to_a;
    e = sel ? enc_b   : enc_a;
    cmp({tag, " grant"},         32'(g), 32'(eg));
    cmp({tag, " grant_valid"},   32'(v), 32'(ev));
    cmp({tag, " grant_encoded"}, 32'(e), 32'(onehot_idx(eg)));
    cmp({tag, " timeout_evt"},   32'(t), 32'(eto));
    $display("[TB] %s dut_%s grant=%b valid=%b enc=%0d timeout_evt=%b",
             tag, sel ? "b" : "a", g, v, e, t);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    // Port 0 weight 3, ports 1..3 weight 1.
    weight = 16'h1113;
    rst_n = 1'b0;
    req_a = '0; ack_a = '0; req_b = '0; ack_b = '0;

    // dut_a: burst of 3 on port 0, then 1,2,3, reload, port 0 leads again.
    add(0, 4'b0001, 4'b0000, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b0001, 4'b0010, 1, 0);
    add(0, 4'b1111, 4'b0010, 4'b0100, 1, 0);
    add(0, 4'b1111, 4'b0100, 4'b1000, 1, 0);
    add(0, 4'b1111, 4'b1000, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b1110, 4'b0001, 1, 0);   // acks to non-grantees ignored
    add(0, 4'b1111, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b1111, 4'b0001, 4'b0010, 1, 0);
    // Port 1 never acked: 8 grant cycles, then revoked with a timeout pulse.
    for (int i = 0; i < 7; i++) add(0, 4'b1111, 4'b0000, 4'b0010, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 1);
    add(0, 4'b1111, 4'b0000, 4'b0100, 1, 0);   // port 1 skipped
    // Port 2: ack lands exactly at count 7, so no timeout.
    for (int i = 0; i < 7; i++) add(0, 4'b1111, 4'b0000, 4'b0100, 1, 0);
    add(0, 4'b1111, 4'b0100, 4'b1000, 1, 0);
    add(0, 4'b1111, 4'b1000, 4'b0001, 1, 0);   // reload, port 0 again
    add(0, 4'b1110, 4'b0000, 4'b0001, 1, 0);   // withdrawn request still held
    add(0, 4'b1110, 4'b0001, 4'b0010, 1, 0);
    add(0, 4'b0000, 4'b0010, 4'b0000, 0, 0);   // idle

    // dut_b: hold while request[2] stays up, despite acks draining credit.
    add(1, 4'b0100, 4'b0000, 4'b0100, 1, 0);
    for (int i = 0; i < 5; i++) add(1, 4'b1111, 4'b0100, 4'b0100, 1, 0);
    add(1, 4'b1011, 4'b0000, 4'b0010, 1, 0);
    add(1, 4'b1011, 4'b0010, 4'b0010, 1, 0);
    add(1, 4'b1001, 4'b0000, 4'b0001, 1, 0);
    add(1, 4'b1000, 4'b0001, 4'b1000, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check_dut(0, 4'b0000, 0, 0, "reset");
    check_dut(1, 4'b0000, 0, 0, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].sel) begin
        req_b = vecs[i].req; ack_b = vecs[i].ack; req_a = '0; ack_a = '0;
      end else begin
        req_a = vecs[i].req; ack_a = vecs[i].ack; req_b = '0; ack_b = '0;
      end
      @(posedge clk); #1;
      check_dut(vecs[i].sel, vecs[i].exp_grant, vecs[i].exp_valid, vecs[i].exp_to,
                $sformatf("vec%0d", i));
    end

    // Mid-burst reset on both instances.
    @(negedge clk);
    req_a = 4'b1111; ack_a = '0; req_b = 4'b1111; ack_b = '0;
    @(posedge clk); #1;
    check_dut(0, 4'b0100, 1, 0, "burst");
    check_dut(1, 4'b0001, 1, 0, "burst");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_dut(0, 4'b0000, 0, 0, "midreset");
    check_dut(1, 4'b0000, 0, 0, "midreset");
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 4'b1010; req_b = 4'b1010;
    @(posedge clk); #1;
    check_dut(0, 4'b0010, 1, 0, "postreset");
    check_dut(1, 4'b1000, 1, 0, "postreset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arbiter_wrr.md
Name: arbiter_wrr

Overview:
- Parametrised weighted round-robin arbiter. It is the next generation of the generic request/grant arbiter used by the Wishbone interconnect.
- Adds per-port weights (credit counters), selectable grant-hold modes, and a watchdog that forcibly revokes a stuck grant.
- Sits between N bus masters' request lines and the crossbar/mux select logic. Downstream consumes a one-hot or encoded grant.

Parameters:
- PORTS, 4, number of requesters (≥2).
- WEIGHT_W, 4, width of each per-port weight/credit field.
- ARB_LSB_HIGH_PRIORITY, 0, 1 = lowest index wins ties and round-robin scans upward; 0 = highest index wins and scan is downward.
- HOLD_MODE, 2, 0 = no hold; 1 = hold while granted request stays asserted; 2 = hold until acknowledge of grantee.
- TIMEOUT, 0, 0 = watchdog off; else maximum consecutive cycles a grant may be held without acknowledge.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- request  input  PORTS  per-port request.
- acknowledge  input  PORTS  per-port transaction-complete strobe.
- weight  input  PORTS*WEIGHT_W  per-port weight, port i at [i*WEIGHT_W +: WEIGHT_W]; quasi-static; sampled only on credit reload.
- grant  output  PORTS  one-hot grant.
- grant_valid  output  1  a grant is active.
- grant_encoded  output  $clog2(PORTS)  index of granted port.
- timeout_evt  output  1  one-cycle pulse when watchdog revokes a grant.

Interface (already decided):
- One clock, clk.
- Reset rst_n is synchronous and active-low: all state clears on the rising clk edge where rst_n=0.

Behaviour:
- Reset values:
  - grant=0, grant_valid=0, grant_encoded=0, timeout_evt=0.
  - All credits=0, round-robin mask=0, watchdog counter=0.
- Latency:
  - Grant is registered: request asserted in cycle N yields grant in cycle N+1 at earliest.
  - All outputs come from flops.
- Eligibility:
  - eligible[i] = request[i] & (credit[i]!=0).
  - If request!=0 and eligible==0, reload every credit[i] from weight[i] in the same cycle. Weight 0 loads as 1.
  - In that reload cycle, arbitrate over request.
- Ack and credit update:
  - ack_hit = grant_valid & acknowledge[grant_encoded].
  - On ack_hit, credit[grant_encoded] decrements, saturating at 0. Acks to non-granted ports are ignored.
  - If acknowledge is tied low, credits never decrement and the grantee stays sticky (documented use).
- Hold (evaluated first; holding keeps grant, grant_encoded and mask unchanged):
  - HOLD_MODE=1: hold while request[grant_encoded].
  - HOLD_MODE=2: hold while grant_valid & !ack_hit.
  - HOLD_MODE=0: never hold.
- Selection when not holding (priority order):
  1. The current grantee if it is still eligible after this cycle's decrement: burst continuation up to weight transactions.
  2. Otherwise the first eligible port in the round-robin mask, i.e. strictly after the last grantee in scan direction.
  3. Otherwise the first eligible port overall.
  4. If nothing is eligible and request==0: grant_valid=0, grant=0, grant_encoded=0; mask and credits unchanged.
- Mask update on selecting index k:
  - LSB mode: mask = all-ones << (k+1).
  - MSB mode: mask = all-ones >> (PORTS-k).
- Watchdog (TIMEOUT>0):
  - Counter increments each cycle grant_valid & !ack_hit.
  - Counter clears on ack_hit, on a grantee change, or when grant_valid=0.
  - When the counter reaches TIMEOUT-1 with no ack:
    - next cycle grant_valid=0 and grant=0;
    - credit of the revoked port is forced to 0;
    - timeout_evt pulses 1 for exactly that cycle.
  - The following cycle re-arbitrates normally.
- Simultaneous events:
  - An ack that drops credit to 0 while another port requests: the grant moves to the next eligible port in the next cycle, with no idle gap.
  - Ack and timeout in the same cycle: the ack wins and no timeout is raised.
  - A grantee withdrawing its request in HOLD_MODE=2 keeps the grant until its ack or the timeout.
- Reset mid-burst: all outputs drop the next edge; credits clear, so the first post-reset request triggers a reload.

Decomposition:
- Shared package arbiter_pkg holds:
  - HOLD_NONE=0, HOLD_REQ=1, HOLD_ACK=2;
  - the $clog2(PORTS) index-width helper.
- Reuse the existing priority_encoder sub-module: two instances, one unmasked and one masked by the round-robin mask.
- Credit counters, watchdog and grant registers stay in arbiter_wrr.

Test Plan:
- Reset release with request=4'b0001 and weight[0]=3 → grant=0001, grant_encoded=0 one cycle after request; credit[0]=3 after the reload.
- PORTS=4, weights {1,1,1,3} (port3..0 = 1,1,1,3), request=1111, HOLD_MODE=2, ack every grant cycle → port 0 is granted for 3 acks, then ports 1,2,3 for 1 each, then credits reload and port 0 leads again.
- HOLD_MODE=1, port 2 granted, request[2] held 5 cycles with other requests active → grant stays 0100 for all 5 cycles; moves to the next port the cycle after request[2] drops.
- TIMEOUT=8, port 1 granted and never acked → grant_valid stays 1 for 8 cycles, then drops to 0 with timeout_evt=1 for one cycle; port 1 is then skipped until the next reload.
- Ack and timeout coincide at count 7 → timeout_evt stays 0 and credit decrements normally.
- Assert rst_n=0 mid-burst for 1 cycle → grant=0, grant_valid=0 the next cycle; re-request yields a fresh reload and the lowest-priority-index grant per ARB_LSB_HIGH_PRIORITY.
